// File: rtl/dsadc_decim_avg_if.sv
// Sample-in / window-result-out bundle for the decimating averager.
// The master drives samples, window control and result acceptance; the slave returns the result register.
interface dsadc_decim_avg_if #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 2
);
  logic                           in_valid;
  logic signed [WIDTH-1:0]        in_data;
  logic                           sync;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [WIDTH+LOG2N-1:0]  out_sum;
  logic signed [WIDTH-1:0]        out_data;
  logic                           overrun;
  logic                           clr_overrun;

  modport master (
    output in_valid, in_data, sync, out_ready, clr_overrun,
    input  out_valid, out_sum, out_data, overrun
  );

  modport slave (
    input  in_valid, in_data, sync, out_ready, clr_overrun,
    output out_valid, out_sum, out_data, overrun
  );
endinterface

// File: rtl/dsadc_decim_avg.sv
// Sums non-overlapping windows of 2^LOG2N signed samples and presents sum and floor-average in a valid/ready
// register; result visible 1 cycle after the Nth sample, no input back-pressure, lost results set sticky overrun.
module dsadc_decim_avg #(
  parameter int WIDTH = 8,
  parameter int LOG2N = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  dsadc_decim_avg_if.slave      bus
);
  localparam int SW = WIDTH + LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'((1 << LOG2N) - 1);

  logic signed [SW-1:0] acc_q, acc_d;
  logic [LOG2N-1:0]     cnt_q, cnt_d;
  logic signed [SW-1:0] out_sum_q, out_sum_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;

  logic signed [SW-1:0] sample_ext;
  logic signed [SW-1:0] acc_plus;
  logic                 complete;
  logic                 lost;

  always_comb begin
    sample_ext = {{LOG2N{bus.in_data[WIDTH-1]}}, bus.in_data};
    acc_plus   = acc_q + sample_ext;
    // A sync in the final-sample cycle restarts the window instead of completing it.
    complete   = bus.in_valid && !bus.sync && (cnt_q == CNT_LAST);
    lost       = complete && out_valid_q && !bus.out_ready;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (bus.sync) begin
      acc_d = bus.in_valid ? sample_ext : '0;
      cnt_d = bus.in_valid ? LOG2N'(1) : '0;
    end else if (complete) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.in_valid) begin
      acc_d = acc_plus;
      cnt_d = cnt_q + LOG2N'(1);
    end

    if (complete) begin
      out_sum_d   = acc_plus;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (lost) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_data  = WIDTH'(out_sum_q >>> LOG2N);
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_dsadc_decim_avg.sv
// Directed cycle table plus reset, gapped-streaming and mid-window-reset sequences for dsadc_decim_avg (WIDTH=8, N=4).
module tb_dsadc_decim_avg;
  localparam int WIDTH = 8;
  localparam int LOG2N = 2;
  localparam int SW    = WIDTH + LOG2N;

  logic clk;
  logic rstn;

  dsadc_decim_avg_if #(.WIDTH(WIDTH), .LOG2N(LOG2N)) bus ();

  dsadc_decim_avg #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    int          d;
    logic        s;
    logic        r;
    logic        c;
    logic        ev;
    int          esum;
    int          edata;
    logic        eovr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic v, input int d, input logic s, input logic r, input logic c,
                     input logic ev, input int esum, input int edata, input logic eovr);
    vec_t t;
    t.v = v; t.d = d; t.s = s; t.r = r; t.c = c;
    t.ev = ev; t.esum = esum; t.edata = edata; t.eovr = eovr;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input int d, input logic s, input logic r, input logic c);
    bus.in_valid    = v;
    bus.in_data     = WIDTH'(d);
    bus.sync        = s;
    bus.out_ready   = r;
    bus.clr_overrun = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input int esum, input int edata, input logic eovr);
    logic [SW-1:0]    es;
    logic [WIDTH-1:0] ed;
    es = SW'(esum);
    ed = WIDTH'(edata);
    n_checks++;
    if (bus.out_valid === ev && bus.out_sum === es && bus.out_data === ed && bus.overrun === eovr) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got valid=%0b sum=%0d data=%0d ovr=%0b, want valid=%0b sum=%0d data=%0d ovr=%0b",
               name, bus.out_valid, bus.out_sum, bus.out_data, bus.overrun,
               ev, $signed(es), $signed(ed), eovr);
    end
  endtask

  initial begin
    int acc;
    int cnt;
    int exp_sum;
    int exp_data;
    logic exp_v;
    logic v;
    int d;

    // v  d   s r c | ev sum data ovr
    add(1,  15, 0,1,0, 0,   0,   0,0);
    add(1,  15, 0,1,0, 0,   0,   0,0);
    add(1,  15, 0,1,0, 0,   0,   0,0);
    add(1,  15, 0,1,0, 1,  60,  15,0);
    add(1, 127, 0,1,0, 0,  60,  15,0);
    add(1, 127, 0,1,0, 0,  60,  15,0);
    add(1, 127, 0,1,0, 0,  60,  15,0);
    add(1, 127, 0,1,0, 1, 508, 127,0);
    add(1,-128, 0,1,0, 0, 508, 127,0);
    add(1,-128, 0,1,0, 0, 508, 127,0);
    add(1,-128, 0,1,0, 0, 508, 127,0);
    add(1,-128, 0,1,0, 1,-512,-128,0);
    add(1,  -1, 0,1,0, 0,-512,-128,0);
    add(1,   0, 0,1,0, 0,-512,-128,0);
    add(1,   0, 0,1,0, 0,-512,-128,0);
    add(1,   0, 0,1,0, 1,  -1,  -1,0);
    add(1,   1, 0,1,0, 0,  -1,  -1,0);
    add(1,   0, 0,1,0, 0,  -1,  -1,0);
    add(1,   0, 0,1,0, 0,  -1,  -1,0);
    add(1,   0, 0,1,0, 1,   1,   0,0);
    add(0,   0, 0,1,0, 0,   1,   0,0);
    // back-pressure: first window held, second overwrites it
    add(1,  15, 0,0,0, 0,   1,   0,0);
    add(1,  15, 0,0,0, 0,   1,   0,0);
    add(1,  15, 0,0,0, 0,   1,   0,0);
    add(1,  15, 0,0,0, 1,  60,  15,0);
    add(1, -50, 0,0,0, 1,  60,  15,0);
    add(1, -50, 0,0,0, 1,  60,  15,0);
    add(1, -50, 0,0,0, 1,  60,  15,0);
    add(1, -50, 0,0,0, 1,-200, -50,1);
    add(0,   0, 0,0,1, 1,-200, -50,0);
    // clear coinciding with a fresh overrun: set wins
    add(1, 127, 0,0,0, 1,-200, -50,0);
    add(1, 127, 0,0,0, 1,-200, -50,0);
    add(1, 127, 0,0,0, 1,-200, -50,0);
    add(1, 127, 0,0,1, 1, 508, 127,1);
    add(0,   0, 0,1,1, 0, 508, 127,0);
    // sync with a sample discards the two 50s
    add(1,  50, 0,1,0, 0, 508, 127,0);
    add(1,  50, 0,1,0, 0, 508, 127,0);
    add(1,  10, 1,1,0, 0, 508, 127,0);
    add(1,  10, 0,1,0, 0, 508, 127,0);
    add(1,  10, 0,1,0, 0, 508, 127,0);
    add(1,  10, 0,1,0, 1,  40,  10,0);
    // sync on the would-be final sample restarts instead of completing
    add(1,  10, 0,1,0, 0,  40,  10,0);
    add(1,  10, 0,1,0, 0,  40,  10,0);
    add(1,  10, 0,1,0, 0,  40,  10,0);
    add(1,  10, 1,1,0, 0,  40,  10,0);
    add(1,  20, 0,1,0, 0,  40,  10,0);
    add(1,  20, 0,1,0, 0,  40,  10,0);
    add(1,  20, 0,1,0, 1,  70,  17,0);
    add(0,   0, 1,0,0, 1,  70,  17,0);
    // completion in the same cycle as a transfer
    add(1,  -7, 0,0,0, 1,  70,  17,0);
    add(1,  -7, 0,0,0, 1,  70,  17,0);
    add(1,  -7, 0,0,0, 1,  70,  17,0);
    add(1,  -7, 0,1,0, 1, -28,  -7,0);
    add(0,   0, 0,1,0, 0, -28,  -7,0);

    rstn = 1'b0;
    drive(1, 15, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_%0d", i), 0, 0, 0, 0);
    end
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].r, vecs[i].c);
      step();
      check($sformatf("vec_%0d", i), vecs[i].ev, vecs[i].esum, vecs[i].edata, vecs[i].eovr);
    end

    // gapped streaming, always ready
    acc = 0;
    cnt = 0;
    exp_sum = -28;
    exp_data = -7;
    for (int i = 0; i < 200; i++) begin
      v = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, 255)) - 128;
      drive(v, d, 0, 1, 0);
      step();
      exp_v = 1'b0;
      if (v) begin
        acc += d;
        cnt++;
        if (cnt == 4) begin
          exp_v    = 1'b1;
          exp_sum  = acc;
          exp_data = (acc - (((acc % 4) + 4) % 4)) / 4;
          acc = 0;
          cnt = 0;
        end
      end
      check($sformatf("stream_%0d", i), exp_v, exp_sum, exp_data, 0);
    end

    // reset mid-window drops partial sum and pending result
    drive(1, 5, 0, 0, 0);
    step();
    step();
    rstn = 1'b0;
    step();
    check("midreset", 0, 0, 0, 0);
    rstn = 1'b1;
    drive(1, 5, 0, 0, 0);
    step();
    step();
    step();
    check("post_reset_3rd", 0, 0, 0, 0);
    step();
    check("post_reset_4th", 1, 20, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dsadc_decim_avg.md
# dsadc_decim_avg

Downstream post-processing stage for the delta-sigma ADC model. Consumes signed WIDTH-bit `dig_out` samples, accumulates non-overlapping windows of 2^LOG2N samples, and emits the window sum and the floor-average through a valid/ready output register. A sticky overrun flag records any result lost to back-pressure. Feeds the bench scoreboard and any downstream logic that needs a lower-rate, lower-noise reading.

## Interface
Parameters:
- WIDTH, 8, input/average sample width (signed two's complement), same as the ADC `dig_out`.
- LOG2N, 2, log2 of window length; N = 2^LOG2N, LOG2N ≥ 1.

Ports:
- clk  in  1  sample clock (same clock as ADC `dig_out`).
- rstn  in  1  synchronous active-low reset. Sampled on the clk rising edge only.
- in_valid  in  1  in_data holds a sample this cycle.
- in_data  in  WIDTH  signed sample from ADC.
- sync  in  1  restart window: discard the partial accumulation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH+LOG2N  signed window sum.
- out_data  out  WIDTH  signed average = out_sum >>> LOG2N.
- overrun  out  1  sticky: a result was overwritten before it was taken.
- clr_overrun  in  1  clears overrun.

## Operation
- State: acc (signed WIDTH+LOG2N), cnt (LOG2N bits), output register {out_sum, out_valid}, overrun.
- Reset (rstn=0 at a clk edge): acc=0, cnt=0, out_valid=0, out_sum=0, out_data=0, overrun=0.
- Accept: every cycle with in_valid=1 takes in_data. There is no input back-pressure.
- Sign-extend in_data to WIDTH+LOG2N bits before adding. The sum cannot overflow: the range is [-2^(WIDTH-1)·N, (2^(WIDTH-1)-1)·N].
- Non-final sample (cnt<N-1): acc<=acc+in_data; cnt<=cnt+1.
- Final sample (cnt==N-1): out_sum<=acc+in_data; out_valid<=1; acc<=0; cnt<=0.
- out_data is the arithmetic right shift of out_sum, rounding toward −∞. It is combinational from the registered out_sum.
- Handshake: out_valid, out_sum and out_data hold steady while out_valid=1 and out_ready=0. out_valid falls the cycle after out_valid&&out_ready, unless a new result loads in that same cycle.
- A completion in the same cycle as a transfer loads the new result. out_valid stays 1, overrun unaffected.
- A completion while out_valid=1 and out_ready=0 overwrites the output register and sets overrun<=1.
- sync=1: acc<=0, cnt<=0. The output register is untouched. If in_valid=1 in the same cycle, that sample becomes the first of the new window (acc<=in_data, cnt<=1). A sync coinciding with a would-be final sample does not complete the window.
- clr_overrun=1 clears overrun, except when a new overrun is set in the same cycle. Set wins.

## Timing
- Latency: out_valid rises at the edge that accepts the Nth sample. It is visible 1 cycle after that in_valid cycle.
- Maximum throughput: one result every N accepted samples, with zero bubbles when out_ready=1.
- All outputs are registered. There is no combinational path from in_* or out_ready to any output.
- Reset mid-window discards the partial sum and any pending result. The first window after reset starts on the first accepted sample.

## Test plan
- Reset: hold rstn=0 for 3 cycles with in_valid=1 → all outputs 0. After release, 4 samples of 15 → out_sum=60, out_data=15, out_valid one cycle after the 4th sample.
- Extremes: 4×127 → out_sum=508, out_data=127. 4×(−128) → out_sum=−512, out_data=−128. 4×(−50) → −200/−50.
- Floor rounding: samples −1,0,0,0 → out_sum=−1, out_data=−1. Samples 1,0,0,0 → out_sum=1, out_data=0.
- Back-pressure/overrun: out_ready=0 over two windows (15s then −50s) → first result holds until overwritten, then −200 shown with overrun=1. clr_overrun → overrun=0. Clr coinciding with a new overrun → stays 1.
- Sync: 2 samples of 50, then sync with in_valid and 10, then 3×10 → out_sum=40 (the 50s are discarded).
- Gapped input and streaming: in_valid toggled randomly with out_ready=1 → every 4 accepted samples yield one correct sum. Completion coinciding with a transfer → out_valid stays high, no overrun.
